// File: rtl/parity_serializer_pkg.sv
// Shared types and constants for the serial parity link transmitter.
// Holds the FSM state encoding, the default payload width and the parity selection codes.
package parity_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/parity_serializer_piso_parity_shifter.sv
// Parallel-in serial-out shifter with a running XOR parity bit.
// The serial output is a flop, so load/shift/emit_parity decide what appears on the next cycle.
module piso_parity_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  emit_parity,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  seq_out
);

    localparam logic ODD_BIT = (ODD_PARITY != 0);

    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parity_q;
    logic                  seq_out_q;

    // Bit 0 goes straight to the output on load, so the register keeps only the remaining bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            parity_q  <= 1'b0;
            seq_out_q <= 1'b0;
        end else if (load) begin
            shift_q   <= {1'b0, load_data[DATA_WIDTH-1:1]};
            parity_q  <= load_data[0];
            seq_out_q <= load_data[0];
        end else if (shift) begin
            shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            parity_q  <= parity_q ^ shift_q[0];
            seq_out_q <= shift_q[0];
        end else if (emit_parity) begin
            seq_out_q <= parity_q ^ ODD_BIT;
        end else begin
            seq_out_q <= 1'b0;
        end
    end

    assign seq_out = seq_out_q;

endmodule

// File: rtl/parity_serializer.sv
// Serial parity link transmitter: accepts words on valid/ready, sends them LSB-first plus one parity bit.
// Holds the frame FSM, bit counter and handshake; the datapath lives in piso_parity_shifter.
module parity_serializer
    import parity_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ODD_PARITY = PARITY_EVEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  seqOut,
    output logic                  seqValid,
    output logic                  frameEnd,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             seq_valid_q, frame_end_q;
    logic             seq_valid_d, frame_end_d;
    logic             handshake;
    logic             load, shift, emit_parity;

    // Ready comes from registered state only, never from in_valid.
    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_PARITY);
    assign handshake = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        shift       = 1'b0;
        emit_parity = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    load    = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == LAST_CNT) begin
                    emit_parity = 1'b1;
                    state_d     = ST_PARITY;
                end else begin
                    shift = 1'b1;
                end
            end
            ST_PARITY: begin
                if (handshake) begin
                    load    = 1'b1;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        seq_valid_d = (state_d != ST_IDLE);
        frame_end_d = (state_d == ST_PARITY);
    end

    // Counter tracks the index of the bit currently on seqOut.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
        end else if (load) begin
            bit_cnt_q <= '0;
        end else if (shift) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            seq_valid_q <= seq_valid_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign seqValid = seq_valid_q;
    assign frameEnd = frame_end_q;

    piso_parity_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .ODD_PARITY (ODD_PARITY)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .shift       (shift),
        .emit_parity (emit_parity),
        .load_data   (in_data),
        .seq_out     (seqOut)
    );

endmodule
